ifu_fetch_packer: RTL and testbench

- Upstream neighbour of the IFU fetch queue.
- Takes one 8-slot (256-bit) I-cache fetch line per handshake, plus a start slot and an optional taken-branch end slot.
- Compacts the live slots to lanes 0..N-1, holds them in one output register stage, and pushes them into the fetch queue only when the queue has room for the whole packet.
- Drives the queue's per-lane valids, data and one-hot valid-count decode.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fetch_compact.sv | 37 +++
 rtl/ifu_fetch_packer.sv | 111 +++++++++++
 tb/tb_ifu_fetch_packer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants, types and count decode for the IFU fetch packer
package ifu_pkg;

    localparam int IFU_FETCH_SLOTS = 8;
    localparam int IFU_INST_W      = 32;
    localparam int IFU_FQ_DEPTH    = 32;
    localparam int IFU_FQ_CNT_W    = $clog2(IFU_FQ_DEPTH + 1);

    typedef logic [IFU_INST_W-1:0]   ifu_inst_t;
    typedef logic [2:0]              ifu_slot_idx_t;
    typedef logic [IFU_FQ_CNT_W-1:0] ifu_fq_cnt_t;

    // One-hot of (cnt-1): bit k set means k+1 instructions; zero for cnt 0 or out of range
    function automatic logic [IFU_FETCH_SLOTS-1:0] ifu_cnt_onehot(input logic [3:0] cnt);
        logic [IFU_FETCH_SLOTS-1:0] oh;
        oh = '0;
        if ((cnt != 4'd0) && (cnt <= 4'd8)) begin
            oh[3'(cnt - 4'd1)] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ifu_fetch_compact.sv
// rtl/ifu_fetch_compact.sv - combinational live-slot count and lane compaction of one fetch line
module ifu_fetch_compact
    import ifu_pkg::*;
(
    input  logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] line_data,
    input  ifu_slot_idx_t                         start_slot,
    input  logic                                  br_taken,
    input  ifu_slot_idx_t                         br_slot,
    output logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] lane_data,
    output logic [3:0]                            count,
    output logic                                  br_illegal
);

    ifu_slot_idx_t end_slot;
    logic [3:0]    src;

    // A taken branch below the start slot cannot be real; it is treated as not taken
    assign br_illegal = br_taken && (br_slot < start_slot);

    // Pick the last live slot, count live slots, shift them down to lane 0 with no wrap
    always_comb begin
        end_slot = 3'd7;
        if (br_taken && (br_slot >= start_slot)) begin
            end_slot = br_slot;
        end
        count     = {1'b0, end_slot} - {1'b0, start_slot} + 4'd1;
        lane_data = '0;
        src       = '0;
        for (int i = 0; i < IFU_FETCH_SLOTS; i++) begin
            src = {1'b0, start_slot} + 4'(i);
            if (4'(i) < count) begin
                lane_data[i*IFU_INST_W +: IFU_INST_W] = line_data[src[2:0]*IFU_INST_W +: IFU_INST_W];
            end
        end
    end

endmodule

// File: rtl/ifu_fetch_packer.sv
// rtl/ifu_fetch_packer.sv - fetch line packer feeding the fetch queue; IFU_FETCH_PACKER_PERF_EN adds perf counters
module ifu_fetch_packer
    import ifu_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  line_valid,
    output logic                                  line_ready,
    input  logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] line_data,
    input  ifu_slot_idx_t                         line_start_slot,
    input  logic                                  line_br_taken,
    input  ifu_slot_idx_t                         line_br_slot,
    input  ifu_fq_cnt_t                           fq_free_cnt,
    output logic [IFU_FETCH_SLOTS-1:0]            fq_inst_valid_num_dcd,
    output logic [IFU_FETCH_SLOTS-1:0]            fq_inst_valid,
    output logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] fq_inst,
`ifdef IFU_FETCH_PACKER_PERF_EN
    output logic [31:0]                           perf_stall_cnt,
    output logic [31:0]                           perf_inst_cnt,
`endif
    output logic [3:0]                            fq_push_num
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } pack_state_t;

    pack_state_t                           state_q;
    pack_state_t                           state_d;
    logic [3:0]                            held_count;
    logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] held_data;
    logic [IFU_FETCH_SLOTS*IFU_INST_W-1:0] lane_data;
    logic [3:0]                            lane_count;
    logic                                  br_illegal;
    logic                                  held_valid;
    logic                                  push;
    logic                                  accept;
    logic [8:0]                            valid_mask;

    ifu_fetch_compact u_compact (
        .line_data  (line_data),
        .start_slot (line_start_slot),
        .br_taken   (line_br_taken),
        .br_slot    (line_br_slot),
        .lane_data  (lane_data),
        .count      (lane_count),
        .br_illegal (br_illegal)
    );

    assign held_valid = (state_q == ST_FULL);
    assign valid_mask = (9'd1 << held_count) - 9'd1;

    // Packet is pushed whole or not at all; a new line may replace it in the same cycle
    always_comb begin
        push       = held_valid && !flush && (fq_free_cnt >= {2'b00, held_count});
        line_ready = !flush && (!held_valid || push);
        accept     = line_valid && line_ready;
        state_d    = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (push) begin
            state_d = ST_EMPTY;
        end
        fq_inst_valid         = push ? valid_mask[7:0] : '0;
        fq_inst_valid_num_dcd = push ? ifu_cnt_onehot(held_count) : '0;
        fq_push_num           = push ? held_count : 4'd0;
        fq_inst               = held_data;
    end

    // Output register stage: state, count and compacted lanes load on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            held_count <= 4'd0;
            held_data  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                held_count <= lane_count;
                held_data  <= lane_data;
            end
        end
    end

    // Illegal branch slot should never be presented by the predictor
    assert property (@(posedge clk) disable iff (!rst_n) !(line_valid && br_illegal))
        else $warning("illegal taken-branch slot below start slot, treated as not taken");

`ifdef IFU_FETCH_PACKER_PERF_EN
    logic [32:0] inst_sum;
    assign inst_sum = {1'b0, perf_inst_cnt} + {29'd0, fq_push_num};

    // Saturating stall-cycle and pushed-instruction counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_inst_cnt  <= '0;
        end else begin
            if (held_valid && !push && !flush && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            perf_inst_cnt <= inst_sum[32] ? '1 : inst_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_packer.sv
// tb/tb_ifu_fetch_packer.sv - self-checking bench for ifu_fetch_packer against a behavioural packet model
module tb_ifu_fetch_packer;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         line_valid;
    logic         line_ready;
    logic [255:0] line_data;
    logic [2:0]   line_start_slot;
    logic         line_br_taken;
    logic [2:0]   line_br_slot;
    logic [5:0]   fq_free_cnt;
    logic [7:0]   fq_inst_valid_num_dcd;
    logic [7:0]   fq_inst_valid;
    logic [255:0] fq_inst;
    logic [3:0]   fq_push_num;
`ifdef IFU_FETCH_PACKER_PERF_EN
    logic [31:0]  perf_stall_cnt;
    logic [31:0]  perf_inst_cnt;
`endif

    ifu_fetch_packer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .flush                 (flush),
        .line_valid            (line_valid),
        .line_ready            (line_ready),
        .line_data             (line_data),
        .line_start_slot       (line_start_slot),
        .line_br_taken         (line_br_taken),
        .line_br_slot          (line_br_slot),
        .fq_free_cnt           (fq_free_cnt),
        .fq_inst_valid_num_dcd (fq_inst_valid_num_dcd),
        .fq_inst_valid         (fq_inst_valid),
        .fq_inst               (fq_inst),
`ifdef IFU_FETCH_PACKER_PERF_EN
        .perf_stall_cnt        (perf_stall_cnt),
        .perf_inst_cnt         (perf_inst_cnt),
`endif
        .fq_push_num           (fq_push_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: one held packet as a valid flag, an instruction count and a list of lane words
    bit          m_valid;
    int          m_count;
    logic [31:0] m_lane [8];
    logic [31:0] cur_w  [8];
    logic [31:0] saved_w[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_count = 0;
        for (int i = 0; i < 8; i++) m_lane[i] = '0;
    endtask

    function automatic bit model_push();
        return m_valid && !flush && (int'(fq_free_cnt) >= m_count);
    endfunction

    // Compare every DUT output to the model at the falling edge
    task automatic tick_check(input string tag);
        bit           p;
        int           n;
        logic [255:0] exp_inst;
        if (!rst_n) model_reset();
        @(negedge clk);
        p = model_push();
        n = p ? m_count : 0;
        for (int i = 0; i < 8; i++) exp_inst[i*32 +: 32] = m_lane[i];
        chk({tag, " line_ready"}, 256'(line_ready), 256'(!flush && (!m_valid || p)));
        chk({tag, " fq_inst_valid"}, 256'(fq_inst_valid), 256'((1 << n) - 1));
        chk({tag, " fq_dcd"}, 256'(fq_inst_valid_num_dcd), n == 0 ? 256'(0) : 256'(1 << (n - 1)));
        chk({tag, " fq_push_num"}, 256'(fq_push_num), 256'(n));
        chk({tag, " fq_inst"}, fq_inst, exp_inst);
    endtask

    // Apply the clock edge to the model, then move to just after that edge
    task automatic tick_adv();
        bit p;
        bit rdy;
        int e;
        int c;
        if (rst_n) begin
            p   = model_push();
            rdy = !flush && (!m_valid || p);
            if (flush) begin
                m_valid = 0;
            end else if (line_valid && rdy) begin
                e = (line_br_taken && line_br_slot >= line_start_slot) ? int'(line_br_slot) : 7;
                c = e - int'(line_start_slot) + 1;
                for (int i = 0; i < 8; i++) m_lane[i] = (i < c) ? cur_w[int'(line_start_slot) + i] : 32'd0;
                m_valid = 1;
                m_count = c;
            end else if (p) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        tick_check(tag);
        tick_adv();
    endtask

    task automatic set_line(input bit v, input int st, input bit bt, input int bs);
        line_valid      = v;
        line_start_slot = 3'(st);
        line_br_taken   = bt;
        line_br_slot    = 3'(bs);
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = $urandom;
            line_data[i*32 +: 32] = cur_w[i];
        end
    endtask

    initial begin
        int st;
        rst_n       = 1'b0;
        flush       = 1'b0;
        fq_free_cnt = 6'd32;
        set_line(0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        tick_check("reset");
        chk("reset fq_inst zero", fq_inst, '0);
        chk("reset line_ready", 256'(line_ready), 256'(1));
        tick_adv();
        rst_n = 1'b1;
        step("idle");

        // Full line from slot 0 pushes all 8 lanes one cycle later
        set_line(1, 0, 0, 0);
        saved_w = cur_w;
        step("full load");
        set_line(0, 0, 0, 0);
        tick_check("full push");
        chk("full valid", 256'(fq_inst_valid), 256'(8'hFF));
        chk("full dcd", 256'(fq_inst_valid_num_dcd), 256'(8'h80));
        chk("full num", 256'(fq_push_num), 256'(8));
        chk("full lane7", 256'(fq_inst[255:224]), 256'(saved_w[7]));
        tick_adv();

        // Start 5 with taken branch at 6 leaves two lanes
        set_line(1, 5, 1, 6);
        saved_w = cur_w;
        step("br load");
        set_line(0, 0, 0, 0);
        tick_check("br push");
        chk("br valid", 256'(fq_inst_valid), 256'(8'h03));
        chk("br dcd", 256'(fq_inst_valid_num_dcd), 256'(8'h02));
        chk("br lane0", 256'(fq_inst[31:0]), 256'(saved_w[5]));
        chk("br lane1", 256'(fq_inst[63:32]), 256'(saved_w[6]));
        chk("br upper zero", 256'(fq_inst[255:64]), '0);
        tick_adv();

        // Held count 4 stalls on free 3, then pushes when free reaches 4
        set_line(1, 4, 0, 0);
        step("stall load");
        fq_free_cnt = 6'd3;
        for (int k = 0; k < 5; k++) begin
            set_line(1, 1, 0, 0);
            tick_check("stall");
            chk("stall ready", 256'(line_ready), 256'(0));
            chk("stall num", 256'(fq_push_num), 256'(0));
            tick_adv();
        end
        fq_free_cnt = 6'd4;
        tick_check("stall release");
        chk("release num", 256'(fq_push_num), 256'(4));
        chk("release ready", 256'(line_ready), 256'(1));
        tick_adv();

        // Back-to-back lines with an empty queue push every cycle
        fq_free_cnt = 6'd32;
        for (int k = 0; k < 10; k++) begin
            st = $urandom_range(0, 7);
            set_line(1, st, 0, 0);
            tick_check("stream");
            chk("stream ready", 256'(line_ready), 256'(1));
            if (k > 0) chk("stream pushes", 256'(fq_push_num != 0), 256'(1));
            tick_adv();
        end

        // Flush while stalled on a full packet
        set_line(1, 0, 0, 0);
        fq_free_cnt = 6'd5;
        step("flush prep");
        flush = 1'b1;
        tick_check("flush");
        chk("flush num", 256'(fq_push_num), 256'(0));
        chk("flush ready", 256'(line_ready), 256'(0));
        tick_adv();
        flush = 1'b0;
        set_line(0, 0, 0, 0);
        tick_check("after flush");
        chk("after flush ready", 256'(line_ready), 256'(1));
        chk("after flush valid", 256'(fq_inst_valid), 256'(0));
        tick_adv();

        // Reset while stalled discards the held packet
        set_line(1, 4, 0, 0);
        fq_free_cnt = 6'd2;
        step("rst prep");
        step("rst stall");
        rst_n = 1'b0;
        tick_check("mid reset");
        chk("mid reset fq_inst", fq_inst, '0);
        tick_adv();
        rst_n = 1'b1;

        // Illegal branch below start behaves as not taken: slots 6,7
        fq_free_cnt = 6'd32;
        set_line(1, 6, 1, 2);
        step("illegal load");
        set_line(0, 0, 0, 0);
        tick_check("illegal push");
        chk("illegal dcd", 256'(fq_inst_valid_num_dcd), 256'(8'h02));
        chk("illegal valid", 256'(fq_inst_valid), 256'(8'h03));
        tick_adv();

        // Randomized traffic: legal lines, flushes, queue occupancy extremes, occasional reset
        for (int k = 0; k < 3000; k++) begin
            st = $urandom_range(0, 7);
            set_line($urandom_range(0, 3) != 0, st, $urandom_range(0, 1) == 1,
                     st + $urandom_range(0, 7 - st));
            flush = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 3))
                0:       fq_free_cnt = 6'd32;
                1:       fq_free_cnt = 6'd0;
                default: fq_free_cnt = 6'($urandom_range(0, 32));
            endcase
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
